// File: rtl/sys_defs.sv
// Shared system definitions: functional-unit classes and the dispatch entry payload.
package sys_defs;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned FU_W   = 3;

  // Functional-unit class encoding, shared with the decoder
  typedef enum logic [FU_W-1:0] {
    FU_ALU  = 3'b000,
    FU_MULT = 3'b001,
    FU_LSQ  = 3'b011,
    FU_BR   = 3'b100
  } fu_class_e;

  // One buffered instruction
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    fu_class_e         fu;
  } disp_entry_t;

  // True for class codes that map onto a real functional unit
  function automatic logic fu_known(input logic [FU_W-1:0] code);
    case (code)
      3'b000, 3'b001, 3'b011, 3'b100: fu_known = 1'b1;
      default:                        fu_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Instruction buffer for fu_dispatch: circular storage, pointers, occupancy and flush.
module dispatch_fifo
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  disp_entry_t   push_entry,
  input  logic          pop,
  output disp_entry_t   head_entry,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  disp_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers and occupancy; flush wins over push and pop, pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/fu_dispatch.sv
// Functional-unit dispatcher: buffers decoded instructions and issues the head to its FU,
// stalling issue after a branch until it resolves.
// Optional build macro FU_DISPATCH_PERF_EN adds the stall_cycles performance counter.
module fu_dispatch
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [FU_W-1:0]   in_fu,
  input  logic              flush,
  output logic              alu_valid,
  output logic              mult_valid,
  output logic              lsq_valid,
  output logic              br_valid,
  input  logic              alu_ready,
  input  logic              mult_ready,
  input  logic              lsq_ready,
  input  logic              br_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              br_done,
  output logic              illegal,
  output logic [CW-1:0]     count
`ifdef FU_DISPATCH_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_BR = 1'b1
  } state_e;

  state_e      state_q;
  logic        illegal_q;
  disp_entry_t head;
  disp_entry_t new_entry;
  logic        known;
  logic        push;
  logic        issue;
  logic        sel_ready;
  logic        fire;

  assign known     = fu_known(in_fu);
  assign in_ready  = (count < CW'(DEPTH)) && !flush;
  assign push      = in_valid && in_ready && known;
  assign new_entry = '{inst: in_inst, pc: in_pc, fu: fu_class_e'(in_fu)};
  assign issue     = (count != '0) && (state_q == ST_RUN);
  assign fire      = issue && sel_ready;

  dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .push       (push),
    .push_entry (new_entry),
    .pop        (fire),
    .head_entry (head),
    .count      (count)
  );

  // Steer the head to exactly one FU and pick up that FU's ready
  always_comb begin
    alu_valid  = 1'b0;
    mult_valid = 1'b0;
    lsq_valid  = 1'b0;
    br_valid   = 1'b0;
    sel_ready  = 1'b0;
    if (issue) begin
      case (head.fu)
        FU_ALU:  begin alu_valid  = 1'b1; sel_ready = alu_ready;  end
        FU_MULT: begin mult_valid = 1'b1; sel_ready = mult_ready; end
        FU_LSQ:  begin lsq_valid  = 1'b1; sel_ready = lsq_ready;  end
        FU_BR:   begin br_valid   = 1'b1; sel_ready = br_ready;   end
        default: sel_ready = 1'b0;
      endcase
    end
  end

  // Issue FSM: a branch leaving the buffer holds issue until br_done; flush overrides all
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else if (flush) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:     if (fire && head.fu == FU_BR) state_q <= ST_WAIT_BR;
        ST_WAIT_BR: if (br_done) state_q <= ST_RUN;
        default:    state_q <= ST_RUN;
      endcase
    end
  end

  // One-cycle pulse for an accepted handshake with an unknown class
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= in_valid && in_ready && !known;
  end

  assign illegal  = illegal_q;
  assign out_inst = head.inst;
  assign out_pc   = head.pc;

`ifdef FU_DISPATCH_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of cycles an issued instruction waits on its FU
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (issue && !sel_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fu_dispatch.sv
// Scoreboard bench for fu_dispatch with a queue-based reference model.
module tb_fu_dispatch;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock, reset_n;
  logic          in_valid, in_ready, flush, br_done, illegal;
  logic [31:0]   in_inst, in_pc, out_inst, out_pc;
  logic [2:0]    in_fu;
  logic          alu_valid, mult_valid, lsq_valid, br_valid;
  logic          alu_ready, mult_ready, lsq_ready, br_ready;
  logic [CW-1:0] count;
`ifdef FU_DISPATCH_PERF_EN
  logic [31:0]   stall_cycles;
  longint        exp_stall;
`endif

  fu_dispatch #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_fu(in_fu), .flush(flush),
    .alu_valid(alu_valid), .mult_valid(mult_valid), .lsq_valid(lsq_valid), .br_valid(br_valid),
    .alu_ready(alu_ready), .mult_ready(mult_ready), .lsq_ready(lsq_ready), .br_ready(br_ready),
    .out_inst(out_inst), .out_pc(out_pc), .br_done(br_done), .illegal(illegal), .count(count)
`ifdef FU_DISPATCH_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  fu;
  } ent_t;

  ent_t mq[$];     // model buffer contents
  ent_t exp_q[$];  // scoreboard of expected issues
  bit   mwait;     // model is waiting for a branch to resolve
  bit   ill_pend;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] v_act, r_act;
  assign v_act = {br_valid, lsq_valid, mult_valid, alu_valid};
  assign r_act = {br_ready, lsq_ready, mult_ready, alu_ready};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FU slot of a class code: 0 ALU, 1 MULT, 2 LSQ, 3 BR, -1 unknown
  function automatic int fu_idx(input logic [2:0] f);
    case (f)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b100:  return 3;
      default: return -1;
    endcase
  endfunction

  // Reference model: per-cycle expectations, then apply this cycle's handshakes
  always @(negedge clock) begin
    logic [3:0] ev;
    int         hi;
    bit         er;
    if (!reset_n) begin
      mq.delete(); exp_q.delete(); mwait = 0; ill_pend = 0;
`ifdef FU_DISPATCH_PERF_EN
      exp_stall = 0;
`endif
    end else begin
      hi = -1;
      ev = 4'b0;
      if (mq.size() > 0 && !mwait) begin
        hi = fu_idx(mq[0].fu);
        ev = 4'(1 << hi);
      end
      er = (mq.size() < DEPTH) && !flush;
      check("in_ready", 64'(in_ready), 64'(er));
      check("fu_valids", 64'(v_act), 64'(ev));
      check("count", 64'(count), 64'(mq.size()));
      check("illegal", 64'(illegal), 64'(ill_pend));
      if (mq.size() > 0) check("head", {out_inst, out_pc}, {mq[0].inst, mq[0].pc});
`ifdef FU_DISPATCH_PERF_EN
      check("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
      if (hi >= 0 && !r_act[hi]) exp_stall++;
`endif
      if (flush) begin
        mq.delete(); exp_q.delete(); mwait = 0; ill_pend = 0;
      end else begin
        ill_pend = in_valid && er && (fu_idx(in_fu) < 0);
        if (hi >= 0 && r_act[hi]) begin
          if (mq[0].fu == 3'b100) mwait = 1;
          void'(mq.pop_front());
        end else if (mwait && br_done) begin
          mwait = 0;
        end
        if (in_valid && er && fu_idx(in_fu) >= 0) begin
          mq.push_back('{inst: in_inst, pc: in_pc, fu: in_fu});
          exp_q.push_back('{inst: in_inst, pc: in_pc, fu: in_fu});
        end
      end
    end
  end

  // Monitor: every FU handshake must match the oldest expected issue
  always @(negedge clock) begin
    ent_t e;
    if (reset_n && !flush) begin
      for (int i = 0; i < 4; i++) begin
        if (v_act[i] && r_act[i]) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_issue", 64'(i), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("sb_fu", 64'(i), 64'(fu_idx(e.fu)));
            check("sb_inst", 64'(out_inst), 64'(e.inst));
            check("sb_pc", 64'(out_pc), 64'(e.pc));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; br_done = 0;
    alu_ready = 0; mult_ready = 0; lsq_ready = 0; br_ready = 0;
  endtask

  task automatic offer(input logic [2:0] fu, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1; in_fu = fu; in_inst = inst; in_pc = pc;
  endtask

  initial begin
    int r;
    clock = 0; reset_n = 0;
    in_inst = 0; in_pc = 0; in_fu = 0;
    idle();
    repeat (2) step();
    reset_n = 1;
    #1;
    check("reset_out", {out_inst, out_pc}, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_count", 64'(count), 64'd0);

    // ADDI into empty buffer with ALU ready
    alu_ready = 1;
    offer(3'b000, 32'h00100093, 32'h0000_1000);
    step();
    in_valid = 0;
    repeat (3) step();
    idle();

    // Fill to capacity, fifth offer refused, single LSQ drain
    for (int i = 0; i < 5; i++) begin
      offer(3'b011, 32'h0000_2003 + 32'(i), 32'h2000 + 32'(4 * i));
      step();
    end
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 0;
    lsq_ready = 1;
    step();
    lsq_ready = 0;
    check("after_one_pop", 64'(count), 64'(DEPTH - 1));
    step();
    lsq_ready = 1;
    repeat (4) step();
    idle();

    // BEQ then ADD: ALU waits for br_done
    offer(3'b100, 32'h00208463, 32'h3000);
    step();
    offer(3'b000, 32'h002081b3, 32'h3004);
    br_ready = 1;
    step();
    in_valid = 0; br_ready = 0; alu_ready = 1;
    repeat (3) step();
    br_done = 1;
    step();
    br_done = 0;
    repeat (2) step();
    idle();

    // Unknown class dropped with one illegal pulse
    offer(3'b111, 32'hDEAD_BEEF, 32'h4000);
    step();
    in_valid = 0;
    repeat (3) step();

    // Flush with three entries while waiting on a branch, offer in the flush cycle
    offer(3'b100, 32'h0000_0063, 32'h5000);
    step();
    br_ready = 1;
    offer(3'b000, 32'h0000_0013, 32'h5004);
    step();
    br_ready = 0;
    offer(3'b000, 32'h0000_0013, 32'h5008);
    step();
    offer(3'b000, 32'h0000_0013, 32'h500C);
    step();
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1;
    offer(3'b000, 32'h1111_1111, 32'h5010);
    step();
    flush = 0; in_valid = 0;
    check("post_flush_count", 64'(count), 64'd0);
    alu_ready = 1;
    offer(3'b000, 32'h2222_2222, 32'h5014);
    step();
    in_valid = 0;
    repeat (2) step();
    idle();

    // Asynchronous reset between clock edges
    offer(3'b000, 32'h0000_0a13, 32'h6000);
    step();
    offer(3'b001, 32'h0000_0b33, 32'h6004);
    step();
    in_valid = 0;
    @(posedge clock); #3;
    reset_n = 0;
    #1;
    check("async_valids", 64'(v_act), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_illegal", 64'(illegal), 64'd0);
    step();
    reset_n = 1;
    step();

`ifdef FU_DISPATCH_PERF_EN
    // Five stalled MULT cycles after reset
    offer(3'b001, 32'h0220_8033, 32'h7000);
    step();
    in_valid = 0;
    repeat (5) step();
    check("stall_five", 64'(stall_cycles), 64'd5);
    mult_ready = 1;
    step();
    idle();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 9));
      in_valid = ($urandom_range(0, 2) != 0);
      case (r)
        0, 1, 2: in_fu = 3'b000;
        3, 4:    in_fu = 3'b001;
        5, 6:    in_fu = 3'b011;
        7, 8:    in_fu = 3'b100;
        default: in_fu = 3'(2 + 3 * $urandom_range(0, 1) + $urandom_range(0, 1));
      endcase
      in_inst    = $urandom;
      in_pc      = $urandom;
      alu_ready  = $urandom_range(0, 1) != 0;
      mult_ready = $urandom_range(0, 1) != 0;
      lsq_ready  = $urandom_range(0, 1) != 0;
      br_ready   = $urandom_range(0, 1) != 0;
      br_done    = $urandom_range(0, 3) == 0;
      flush      = $urandom_range(0, 39) == 0;
      step();
    end

    // Drain everything still buffered
    idle();
    alu_ready = 1; mult_ready = 1; lsq_ready = 1; br_ready = 1; br_done = 1;
    repeat (3 * DEPTH + 4) step();
    check("drain_scoreboard", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(count), 64'd0);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_dispatch.md
FU_DISPATCH -- requirements
Module: fu_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-buffer entries (power of 2, >=2).
REQ-002 SHALL have ports: clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: in_valid  input  1  decode offers an instruction.
REQ-005 SHALL have ports: in_ready  output  1  buffer accepts an instruction.
REQ-006 SHALL have ports: in_inst  input  32  INST word; in_pc  input  32  PC.
REQ-007 SHALL have ports: in_fu  input  3  decoder FU class.
REQ-008 SHALL have ports: flush  input  1  discard all buffered and waiting work.
REQ-009 SHALL have ports: alu_valid/mult_valid/lsq_valid/br_valid  output  1 each  issue to that FU.
REQ-010 SHALL have ports: alu_ready/mult_ready/lsq_ready/br_ready  input  1 each  FU accepts.
REQ-011 SHALL have ports: out_inst  output  32, out_pc  output  32  head entry, shared by all FUs.
REQ-012 SHALL have ports: br_done  input  1  branch/CSR/WFI resolved.
REQ-013 SHALL have ports: illegal  output  1  one-cycle pulse, dropped unknown class.
REQ-014 SHALL have ports: count  output  $clog2(DEPTH)+1  buffer occupancy.

Function
REQ-015 SHALL treat FU classes as: 000 ALU, 001 MULT, 011 LSQ, 100 BR; all other codes are unknown.
REQ-016 SHALL drive in_ready = (count < DEPTH) && !flush; there is no full-buffer pass-through.
REQ-017 SHALL enqueue when in_valid && in_ready and in_fu is known; occupancy increments next cycle.
REQ-018 SHALL drop an unknown-class handshake without enqueueing it and pulse illegal high the following cycle.
REQ-019 SHALL, with buffer non-empty and state RUN, assert exactly one FU valid (matching the head class), else all FU valids low.
REQ-020 SHALL dequeue the head when its asserted FU valid meets that FU's ready; enqueue and dequeue in the same cycle leave count unchanged.
REQ-021 SHALL give a latency of 1 cycle: an entry enqueued into an empty buffer presents FU valid on the next cycle.
REQ-022 SHALL keep out_inst/out_pc and the asserted valid stable while ready is low.
REQ-023 SHALL use FSM states RUN and WAIT_BR: a BR dequeue moves RUN->WAIT_BR; br_done moves WAIT_BR->RUN; in WAIT_BR all FU valids are low and enqueue continues.
REQ-024 SHALL, on br_done in the same cycle as a BR dequeue, still enter WAIT_BR (br_done applies only in WAIT_BR).
REQ-025 SHALL, on flush, empty the buffer, return to RUN and ignore that cycle's in_valid, with flush priority over enqueue, dequeue and br_done.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-027 SHALL on reset_n low asynchronously clear: count 0, pointers 0, state RUN, all FU valids 0, illegal 0; in_ready is 1 after release; out_inst/out_pc are 0.
REQ-028 SHALL lose all buffered entries and any WAIT_BR state on reset mid-operation.

Configuration
REQ-029 SHALL, with FU_DISPATCH_PERF_EN defined, add output stall_cycles (32 bits), incrementing each cycle a FU valid is high with its ready low, saturating at all-ones, cleared by reset only.
REQ-030 SHALL, without FU_DISPATCH_PERF_EN, omit stall_cycles and its counter entirely.

Structure
REQ-031 SHALL define an FU_CLASS enum in the shared sys_defs package (FU_ALU=3'b000, FU_MULT=3'b001, FU_LSQ=3'b011, FU_BR=3'b100), also used by the decoder.
REQ-032 SHALL place the buffer in sub-module dispatch_fifo (storage, pointers, count, flush); the FSM and steering stay in fu_dispatch.

Verification
REQ-033 SHALL cover: ADDI (class 000) into empty buffer with alu_ready=1 -> alu_valid high on cycle 1 only, count returns to 0.
REQ-034 SHALL cover: 4 enqueues with all readys 0 -> count=4, in_ready=0; 5th in_valid not accepted; lsq_ready=1 for one cycle -> count=3.
REQ-035 SHALL cover: BEQ then ADD queued, br_ready=1 -> br_valid one cycle, alu_valid low until br_done pulse, then alu_valid next cycle.
REQ-036 SHALL cover: in_fu=3'b111 handshake -> count unchanged, illegal high exactly one cycle.
REQ-037 SHALL cover: flush with 3 entries, in WAIT_BR, and in_valid=1 -> count=0, state RUN, nothing enqueued.
REQ-038 SHALL cover: reset_n low mid-stream between clock edges -> all valids 0 and count 0 immediately; with FU_DISPATCH_PERF_EN, 5 stalled mult cycles -> stall_cycles=5.
